// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix job driver: opcodes, result status codes,
// FSM state encoding and per-opcode operand/result counts.
package matrix_pkg;

  localparam logic [7:0] OP_ADD   = 8'd0;
  localparam logic [7:0] OP_SUB   = 8'd1;
  localparam logic [7:0] OP_MUL   = 8'd2;
  localparam logic [7:0] OP_DET   = 8'd3;
  localparam logic [7:0] OP_TRANS = 8'd4;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_BADOP   = 2'd1;
  localparam logic [1:0] ST_TIMEOUT = 2'd2;
  localparam logic [1:0] ST_PROTO   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EN,
    S_OP,
    S_SEND,
    S_WAIT,
    S_RESP
  } mjd_state_t;

  // det and trans only use matrix A; the others stream both matrices
  function automatic logic [3:0] operand_count(input logic [7:0] op);
    return (op == OP_DET || op == OP_TRANS) ? 4'd4 : 4'd8;
  endfunction

  function automatic logic [2:0] result_count(input logic [7:0] op);
    return (op == OP_DET) ? 3'd1 : 3'd4;
  endfunction

endpackage

// File: rtl/mjd_result_capture.sv
// Result write capture for the matrix job driver: slot store, write index,
// address check and the WAIT-state timeout counter.
module mjd_result_capture
  import matrix_pkg::*;
#(
  parameter int DW      = 8,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            active,
  input  logic            is_det,
  input  logic            mp_write_en,
  input  logic [7:0]      mp_address,
  input  logic [DW-1:0]   mp_data_out,
  output logic [4*DW-1:0] slots_nx,
  output logic [2:0]      count_nx,
  output logic            err_nx,
  output logic            timeout
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [4*DW-1:0] slots;
  logic [2:0]      wr_idx;
  logic            err;
  logic [CW-1:0]   cnt;
  logic            wr;
  logic [7:0]      exp_addr;

  assign wr      = active && mp_write_en;
  assign timeout = active && (cnt == CW'(TIMEOUT - 1));

  // next-state view includes a write landing this cycle, so a write that
  // coincides with done is already counted when the driver closes the job
  always_comb begin
    exp_addr = is_det ? 8'd255 : (8'd254 - {5'd0, wr_idx});
    slots_nx = slots;
    count_nx = wr_idx;
    err_nx   = err;
    if (wr) begin
      if (wr_idx < 3'd4) begin
        slots_nx[int'(wr_idx[1:0]) * DW +: DW] = mp_data_out;
      end
      if (mp_address != exp_addr || wr_idx >= 3'd4) begin
        err_nx = 1'b1;
      end
      if (wr_idx != 3'd5) begin
        count_nx = wr_idx + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slots  <= '0;
      wr_idx <= '0;
      err    <= 1'b0;
    end else if (clear) begin
      slots  <= '0;
      wr_idx <= '0;
      err    <= 1'b0;
    end else begin
      slots  <= slots_nx;
      wr_idx <= count_nx;
      err    <= err_nx;
    end
  end

  // counts cycles spent in WAIT; fires on the TIMEOUT-th cycle after the last operand
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (!active) begin
      cnt <= '0;
    end else if (!timeout) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/matrix_job_driver.sv
// Host-side driver for the 2x2 matrix processor: accepts a job, plays it into
// the processor, gathers the result writes and hands back result plus status.
module matrix_job_driver
  import matrix_pkg::*;
#(
  parameter int DW      = 8,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            job_valid,
  output logic            job_ready,
  input  logic [7:0]      job_op,
  input  logic [8*DW-1:0] job_data,
  output logic            mp_en,
  output logic [DW-1:0]   mp_data,
  input  logic [DW-1:0]   mp_data_out,
  input  logic [7:0]      mp_address,
  input  logic            mp_write_en,
  input  logic            mp_done,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [4*DW-1:0] res_data,
  output logic [2:0]      res_count,
  output logic [1:0]      res_status
);

  mjd_state_t state, state_nx;

  logic [7:0]      op_q;
  logic [8*DW-1:0] data_q;
  logic [2:0]      k, k_nx;
  logic            accept;
  logic [3:0]      last_k;

  logic            job_ready_nx, mp_en_nx, res_valid_nx;
  logic [DW-1:0]   mp_data_nx;
  logic [4*DW-1:0] res_data_nx;
  logic [2:0]      res_count_nx;
  logic [1:0]      res_status_nx;

  logic [4*DW-1:0] cap_slots;
  logic [2:0]      cap_count;
  logic            cap_err;
  logic            cap_timeout;

  mjd_result_capture #(.DW(DW), .TIMEOUT(TIMEOUT)) u_capture (
    .clk         (clk),
    .rst         (rst),
    .clear       (accept),
    .active      (state == S_WAIT),
    .is_det      (op_q == OP_DET),
    .mp_write_en (mp_write_en),
    .mp_address  (mp_address),
    .mp_data_out (mp_data_out),
    .slots_nx    (cap_slots),
    .count_nx    (cap_count),
    .err_nx      (cap_err),
    .timeout     (cap_timeout)
  );

  assign last_k = operand_count(op_q) - 4'd1;

  // outputs are computed from the next state and registered alongside it
  always_comb begin
    state_nx      = state;
    k_nx          = k;
    accept        = 1'b0;
    res_data_nx   = res_data;
    res_count_nx  = res_count;
    res_status_nx = res_status;
    mp_data_nx    = '0;

    case (state)
      S_IDLE: begin
        if (job_valid && job_ready) begin
          accept = 1'b1;
          if (job_op > OP_TRANS) begin
            state_nx      = S_RESP;
            res_data_nx   = '0;
            res_count_nx  = 3'd0;
            res_status_nx = ST_BADOP;
          end else begin
            state_nx = S_EN;
          end
        end
      end
      S_EN: state_nx = S_OP;
      S_OP: begin
        state_nx = S_SEND;
        k_nx     = 3'd0;
      end
      S_SEND: begin
        if ({1'b0, k} == last_k) state_nx = S_WAIT;
        else                     k_nx     = k + 3'd1;
      end
      S_WAIT: begin
        if (mp_done || cap_timeout) begin
          state_nx     = S_RESP;
          res_data_nx  = cap_slots;
          res_count_nx = (cap_count > 3'd4) ? 3'd4 : cap_count;
          if (!mp_done)                                        res_status_nx = ST_TIMEOUT;
          else if (cap_err || cap_count != result_count(op_q)) res_status_nx = ST_PROTO;
          else                                                 res_status_nx = ST_OK;
        end
      end
      S_RESP: begin
        if (res_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase

    job_ready_nx = (state_nx == S_IDLE);
    mp_en_nx     = (state_nx == S_EN);
    res_valid_nx = (state_nx == S_RESP);
    if (state_nx == S_OP)   mp_data_nx = DW'(op_q);
    if (state_nx == S_SEND) mp_data_nx = data_q[int'(k_nx) * DW +: DW];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      k          <= '0;
      op_q       <= '0;
      data_q     <= '0;
      job_ready  <= 1'b1;
      mp_en      <= 1'b0;
      mp_data    <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_count  <= '0;
      res_status <= ST_OK;
    end else begin
      state      <= state_nx;
      k          <= k_nx;
      job_ready  <= job_ready_nx;
      mp_en      <= mp_en_nx;
      mp_data    <= mp_data_nx;
      res_valid  <= res_valid_nx;
      res_data   <= res_data_nx;
      res_count  <= res_count_nx;
      res_status <= res_status_nx;
      if (accept) begin
        op_q   <= job_op;
        data_q <= job_data;
      end
    end
  end

endmodule

// File: tb/tb_matrix_job_driver.sv
// Bench for matrix_job_driver: a behavioural matrix processor model answers the
// driver; spec vectors, hand-built corner cases and random jobs are checked.
module tb_matrix_job_driver;
  import matrix_pkg::*;

  localparam int DW      = 8;
  localparam int TIMEOUT = 64;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            job_valid = 1'b0;
  logic            job_ready;
  logic [7:0]      job_op = '0;
  logic [8*DW-1:0] job_data = '0;
  logic            mp_en;
  logic [DW-1:0]   mp_data;
  logic [DW-1:0]   mp_data_out = '0;
  logic [7:0]      mp_address = '0;
  logic            mp_write_en = 1'b0;
  logic            mp_done = 1'b0;
  logic            res_valid;
  logic            res_ready = 1'b0;
  logic [4*DW-1:0] res_data;
  logic [2:0]      res_count;
  logic [1:0]      res_status;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int en_pulses = 0;
  int en_cycle = 0;
  logic stub_hang = 1'b0;
  logic stub_bad_addr = 1'b0;

  typedef struct {
    string           name;
    logic [7:0]      op;
    logic [8*DW-1:0] data;
    logic [4*DW-1:0] elems;
    logic [2:0]      cnt;
    logic [1:0]      st;
    int              lat;
    int              hold;
  } vec_t;

  matrix_job_driver #(.DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready), .job_op(job_op), .job_data(job_data),
    .mp_en(mp_en), .mp_data(mp_data), .mp_data_out(mp_data_out), .mp_address(mp_address),
    .mp_write_en(mp_write_en), .mp_done(mp_done),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_count(res_count), .res_status(res_status)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (mp_en) begin
    en_pulses <= en_pulses + 1;
    en_cycle  <= cyc;
  end

  // Reference 2x2 matrix arithmetic, element order row-major, wrapping to DW bits
  function automatic logic [4*DW-1:0] refElems(input logic [7:0] op, input logic [8*DW-1:0] d);
    int x[8];
    int r[4];
    logic [4*DW-1:0] packed_r;
    for (int i = 0; i < 8; i++) x[i] = int'(d[i*DW +: DW]);
    r = '{0, 0, 0, 0};
    case (op)
      OP_ADD:   r = '{x[0]+x[4], x[1]+x[5], x[2]+x[6], x[3]+x[7]};
      OP_SUB:   r = '{x[0]-x[4], x[1]-x[5], x[2]-x[6], x[3]-x[7]};
      OP_MUL:   r = '{x[0]*x[4]+x[1]*x[6], x[0]*x[5]+x[1]*x[7],
                      x[2]*x[4]+x[3]*x[6], x[2]*x[5]+x[3]*x[7]};
      OP_DET:   r = '{x[0]*x[3]-x[1]*x[2], 0, 0, 0};
      OP_TRANS: r = '{x[0], x[2], x[1], x[3]};
      default:  r = '{0, 0, 0, 0};
    endcase
    packed_r = '0;
    for (int i = 0; i < 4; i++) packed_r[i*DW +: DW] = r[i][DW-1:0];
    return packed_r;
  endfunction

  function automatic int nOperands(input logic [7:0] op);
    return (op == OP_DET || op == OP_TRANS) ? 4 : 8;
  endfunction

  function automatic int nResults(input logic [7:0] op);
    if (op > OP_TRANS) return 0;
    return (op == OP_DET) ? 1 : 4;
  endfunction

  // en at T, opcode T+1, operands, 2 idle cycles, writes, done, res_valid one cycle later
  function automatic int expLatency(input logic [7:0] op);
    if (op > OP_TRANS) return 0;
    return 5 + nOperands(op) + nResults(op);
  endfunction

  function automatic vec_t mk(input string n, input logic [7:0] op, input logic [8*DW-1:0] d,
                              input logic [4*DW-1:0] e, input logic [2:0] c, input logic [1:0] s,
                              input int lat, input int hold);
    vec_t v;
    v.name = n; v.op = op; v.data = d; v.elems = e; v.cnt = c; v.st = s; v.lat = lat; v.hold = hold;
    return v;
  endfunction

  // Processor model: samples mp_data on negedges, drives results #1 after posedges
  initial begin
    logic [7:0]      s_op;
    logic [8*DW-1:0] s_d;
    logic [4*DW-1:0] r;
    int              n, nres;
    forever begin
      @(negedge clk);
      if (rst && mp_en) begin
        @(negedge clk);
        s_op = mp_data;
        n    = nOperands(s_op);
        s_d  = '0;
        for (int i = 0; i < n; i++) begin
          @(negedge clk);
          s_d[i*DW +: DW] = mp_data;
        end
        if (!stub_hang) begin
          r    = refElems(s_op, s_d);
          nres = (s_op == OP_DET) ? 1 : 4;
          repeat (3) @(posedge clk);
          for (int i = 0; i < nres; i++) begin
            #1;
            mp_write_en = 1'b1;
            mp_address  = (s_op == OP_DET) ? 8'd255 : 8'(254 - i);
            if (stub_bad_addr) mp_address = mp_address ^ 8'h01;
            mp_data_out = r[i*DW +: DW];
            @(posedge clk);
          end
          #1;
          mp_write_en = 1'b0;
          mp_done     = 1'b1;
          @(posedge clk);
          #1;
          mp_done = 1'b0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic [4*DW-1:0] e,
                             input logic [2:0] c, input logic [1:0] s);
    check({name, " res_data"}, res_data, e);
    check({name, " res_count"}, res_count, c);
    check({name, " res_status"}, res_status, s);
  endtask

  // Offer a job, return the cycle after acceptance and the first res_valid cycle
  task automatic applyStimulus(input logic [7:0] op, input logic [8*DW-1:0] d,
                               output int t_acc, output int t_rv);
    int budget;
    logic seen;
    budget = 0;
    @(negedge clk);
    while (!job_ready && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    check("job_ready before offer", job_ready, 1'b1);
    job_valid = 1'b1;
    job_op    = op;
    job_data  = d;
    @(posedge clk);
    #1;
    t_acc     = cyc;
    job_valid = 1'b0;
    t_rv      = -1;
    seen      = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (res_valid) begin
        t_rv = cyc;
        seen = 1'b1;
      end
    end
  endtask

  // Hold res_ready low with a competing job offered, then complete the handshake
  task automatic releaseResult(input vec_t v);
    for (int i = 0; i < v.hold; i++) begin
      job_valid = 1'b1;
      job_op    = 8'd7;
      @(negedge clk);
      check({v.name, " hold"}, {res_valid, job_ready, res_data, res_count, res_status},
            {1'b1, 1'b0, v.elems, v.cnt, v.st});
    end
    job_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    @(negedge clk);
    check({v.name, " release"}, {res_valid, job_ready}, 2'b01);
  endtask

  task automatic runVector(input vec_t v);
    int t_acc, t_rv, p0;
    p0 = en_pulses;
    applyStimulus(v.op, v.data, t_acc, t_rv);
    check({v.name, " latency"}, t_rv - t_acc, v.lat);
    check({v.name, " en pulses"}, en_pulses - p0, (v.op > OP_TRANS) ? 1'b0 : 1'b1);
    if (v.op <= OP_TRANS) check({v.name, " en cycle"}, en_cycle, t_acc);
    checkOutput(v.name, v.elems, v.cnt, v.st);
    releaseResult(v);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[9];
    vec_t v;
    int   t, t_acc, t_rv;
    logic [7:0] rop;
    logic [8*DW-1:0] rdata;

    vecs[0] = mk("add",    OP_ADD,   64'h0807060504030201, 32'h0C0A0806, 3'd4, ST_OK,    17, 0);
    vecs[1] = mk("mul",    OP_MUL,   64'h0807060504030201, 32'h322B1613, 3'd4, ST_OK,    17, 1);
    vecs[2] = mk("sub",    OP_SUB,   64'h0807060504030201, 32'hFCFCFCFC, 3'd4, ST_OK,    17, 0);
    vecs[3] = mk("trans",  OP_TRANS, 64'h0807060504030201, 32'h04020301, 3'd4, ST_OK,    13, 0);
    vecs[4] = mk("det",    OP_DET,   64'h0000000006040803, 32'h000000F2, 3'd1, ST_OK,    10, 0);
    vecs[5] = mk("badop",  8'd7,     64'h0807060504030201, 32'h00000000, 3'd0, ST_BADOP,  0, 2);
    vecs[6] = mk("add_hold", OP_ADD, 64'h0807060504030201, 32'h0C0A0806, 3'd4, ST_OK,    17, 5);
    vecs[7] = mk("b2b_add", OP_ADD,  64'h0807060504030201, 32'h0C0A0806, 3'd4, ST_OK,    17, 0);
    vecs[8] = mk("b2b_det", OP_DET,  64'h0000000006040803, 32'h000000F2, 3'd1, ST_OK,    10, 0);

    @(negedge clk);
    check("reset outputs", {job_ready, mp_en, mp_data, res_valid, res_data, res_count, res_status},
          {1'b1, 1'b0, 8'd0, 1'b0, 32'd0, 3'd0, 2'd0});
    rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 9; i++) runVector(vecs[i]);

    // processor never finishes: abort TIMEOUT cycles after the last operand
    stub_hang = 1'b1;
    applyStimulus(OP_ADD, 64'h0807060504030201, t_acc, t_rv);
    check("timeout latency", t_rv - t_acc, 10 + TIMEOUT);
    checkOutput("timeout", 32'd0, 3'd0, ST_TIMEOUT);
    v = mk("timeout", OP_ADD, 0, 32'd0, 3'd0, ST_TIMEOUT, 0, 0);
    releaseResult(v);
    stub_hang = 1'b0;

    // wrong write addresses
    stub_bad_addr = 1'b1;
    applyStimulus(OP_MUL, 64'h0807060504030201, t_acc, t_rv);
    check("badaddr latency", t_rv - t_acc, 17);
    checkOutput("badaddr", 32'h322B1613, 3'd4, ST_PROTO);
    v = mk("badaddr", OP_MUL, 0, 32'h322B1613, 3'd4, ST_PROTO, 0, 0);
    releaseResult(v);
    stub_bad_addr = 1'b0;

    // reset while the fourth operand is on mp_data
    @(negedge clk);
    job_valid = 1'b1;
    job_op    = OP_ADD;
    job_data  = 64'h0807060504030201;
    @(posedge clk);
    #1;
    t         = cyc;
    job_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("operand 3 on bus", {cyc - t, mp_data}, {32'd5, 8'd4});
    rst = 1'b0;
    #1;
    check("mid-job reset outputs",
          {job_ready, mp_en, mp_data, res_valid, res_data, res_count, res_status},
          {1'b1, 1'b0, 8'd0, 1'b0, 32'd0, 3'd0, 2'd0});
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("ready after reset", {job_ready, mp_en, res_valid}, 3'b100);
    repeat (30) @(negedge clk);
    runVector(mk("post_reset_add", OP_ADD, 64'h0807060504030201, 32'h0C0A0806, 3'd4, ST_OK, 17, 0));

    // random jobs against the reference model
    for (int i = 0; i < 20; i++) begin
      rop   = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(5, 255)) : 8'($urandom_range(0, 4));
      rdata = {$urandom, $urandom};
      runVector(mk($sformatf("rand%0d op%0d", i, rop), rop, rdata,
                   (rop > OP_TRANS) ? 32'd0 : refElems(rop, rdata),
                   3'(nResults(rop)), (rop > OP_TRANS) ? ST_BADOP : ST_OK,
                   expLatency(rop), int'($urandom_range(0, 3))));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
